vram_arbiter: RTL and testbench

//  Shares the single framebuffer access port (sel/wr/mask/address/data/ack) between two requesters:
//  M0 = graphite rasterizer, M1 = CPU direct-VRAM window. Sits between them and the framebuffer.

---
 rtl/vram_arbiter.sv | 138 +++++++++++++
 tb/tb_vram_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// Two-master round-robin arbiter for the single framebuffer access port.
// One transaction in flight, registered slave/master outputs, optional ack timeout.
module vram_arbiter #(
   parameter int ADDR_W         = 24,
   parameter int DATA_W         = 16,
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic              clk,
   input  logic              reset_n_i,

   input  logic              m0_sel_i,
   input  logic              m0_wr_i,
   input  logic [3:0]        m0_mask_i,
   input  logic [ADDR_W-1:0] m0_addr_i,
   input  logic [DATA_W-1:0] m0_data_i,
   output logic [DATA_W-1:0] m0_data_o,
   output logic              m0_ack_o,

   input  logic              m1_sel_i,
   input  logic              m1_wr_i,
   input  logic [3:0]        m1_mask_i,
   input  logic [ADDR_W-1:0] m1_addr_i,
   input  logic [DATA_W-1:0] m1_data_i,
   output logic [DATA_W-1:0] m1_data_o,
   output logic              m1_ack_o,

   output logic              s_sel_o,
   output logic              s_wr_o,
   output logic [3:0]        s_mask_o,
   output logic [ADDR_W-1:0] s_addr_o,
   output logic [DATA_W-1:0] s_data_o,
   input  logic [DATA_W-1:0] s_data_i,
   input  logic              s_ack_i,

   output logic [1:0]        grant_o,
   output logic              timeout_o
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_RELEASE
   } state_t;

   state_t           r_state;
   logic             r_last;   // 0 = M0 granted last, 1 = M1 granted last
   logic             r_owner;
   logic [CNT_W-1:0] r_cnt;

   logic w_any;
   logic w_win;
   logic w_timeout_hit;

   assign w_any         = m0_sel_i | m1_sel_i;
   // On a tie the requester not served last wins; a lone requester always wins.
   assign w_win         = (m0_sel_i & m1_sel_i) ? ~r_last : m1_sel_i;
   assign w_timeout_hit = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_LAST);

   // NOTE: all state and outputs update with non-blocking assignments so every
   // read in this block sees the pre-edge value, exactly like the flops it models.
   always_ff @(posedge clk or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_state   <= ST_IDLE;
         r_last    <= 1'b1;
         r_owner   <= 1'b0;
         r_cnt     <= '0;
         s_sel_o   <= 1'b0;
         s_wr_o    <= 1'b0;
         s_mask_o  <= '0;
         s_addr_o  <= '0;
         s_data_o  <= '0;
         grant_o   <= '0;
         timeout_o <= 1'b0;
         m0_ack_o  <= 1'b0;
         m1_ack_o  <= 1'b0;
         m0_data_o <= '0;
         m1_data_o <= '0;
      end else begin
         m0_ack_o <= 1'b0;
         m1_ack_o <= 1'b0;

         case (r_state)
            ST_IDLE: begin
               if (w_any) begin
                  r_owner  <= w_win;
                  s_sel_o  <= 1'b1;
                  s_wr_o   <= w_win ? m1_wr_i   : m0_wr_i;
                  s_mask_o <= w_win ? m1_mask_i : m0_mask_i;
                  s_addr_o <= w_win ? m1_addr_i : m0_addr_i;
                  s_data_o <= w_win ? m1_data_i : m0_data_i;
                  grant_o  <= w_win ? 2'b10 : 2'b01;
                  r_cnt    <= '0;
                  r_state  <= ST_BUSY;
               end
            end

            ST_BUSY: begin
               if (s_ack_i) begin
                  s_sel_o <= 1'b0;
                  if (r_owner) begin
                     m1_ack_o  <= 1'b1;
                     m1_data_o <= s_data_i;
                  end else begin
                     m0_ack_o  <= 1'b1;
                     m0_data_o <= s_data_i;
                  end
                  r_state <= ST_RELEASE;
               end else if (w_timeout_hit) begin
                  s_sel_o   <= 1'b0;
                  timeout_o <= 1'b1;
                  if (r_owner) begin
                     m1_ack_o  <= 1'b1;
                     m1_data_o <= '0;
                  end else begin
                     m0_ack_o  <= 1'b1;
                     m0_data_o <= '0;
                  end
                  r_state <= ST_RELEASE;
               end else if (r_cnt != '1) begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end

            ST_RELEASE: begin
               grant_o <= '0;
               r_last  <= r_owner;
               r_state <= ST_IDLE;
            end

            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: directed scenarios plus randomized traffic,
// checked against a transaction-level round-robin model.
module tb_vram_arbiter;

   localparam int ADDR_W = 24;
   localparam int DATA_W = 16;
   localparam int TO     = 8;

   logic              clk = 1'b0;
   logic              reset_n_i;
   logic              m0_sel_i, m0_wr_i, m1_sel_i, m1_wr_i;
   logic [3:0]        m0_mask_i, m1_mask_i;
   logic [ADDR_W-1:0] m0_addr_i, m1_addr_i;
   logic [DATA_W-1:0] m0_data_i, m1_data_i, m0_data_o, m1_data_o;
   logic              m0_ack_o, m1_ack_o;
   logic              s_sel_o, s_wr_o, s_ack_i;
   logic [3:0]        s_mask_o;
   logic [ADDR_W-1:0] s_addr_o;
   logic [DATA_W-1:0] s_data_o, s_data_i;
   logic [1:0]        grant_o;
   logic              timeout_o;

   int checks = 0;
   int errors = 0;
   int model_last;

   logic              tb_sel  [2];
   logic              tb_wr   [2];
   logic [3:0]        tb_mask [2];
   logic [ADDR_W-1:0] tb_addr [2];
   logic [DATA_W-1:0] tb_data [2];
   logic [1:0]        ack_v;
   logic [DATA_W-1:0] mdata   [2];

   assign m0_sel_i  = tb_sel[0];
   assign m0_wr_i   = tb_wr[0];
   assign m0_mask_i = tb_mask[0];
   assign m0_addr_i = tb_addr[0];
   assign m0_data_i = tb_data[0];
   assign m1_sel_i  = tb_sel[1];
   assign m1_wr_i   = tb_wr[1];
   assign m1_mask_i = tb_mask[1];
   assign m1_addr_i = tb_addr[1];
   assign m1_data_i = tb_data[1];
   assign ack_v     = {m1_ack_o, m0_ack_o};
   assign mdata[0]  = m0_data_o;
   assign mdata[1]  = m1_data_o;

   always #5 clk = ~clk;

   vram_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .reset_n_i(reset_n_i),
      .m0_sel_i(m0_sel_i), .m0_wr_i(m0_wr_i), .m0_mask_i(m0_mask_i),
      .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i), .m0_data_o(m0_data_o), .m0_ack_o(m0_ack_o),
      .m1_sel_i(m1_sel_i), .m1_wr_i(m1_wr_i), .m1_mask_i(m1_mask_i),
      .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i), .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o),
      .s_sel_o(s_sel_o), .s_wr_o(s_wr_o), .s_mask_o(s_mask_o), .s_addr_o(s_addr_o),
      .s_data_o(s_data_o), .s_data_i(s_data_i), .s_ack_i(s_ack_i),
      .grant_o(grant_o), .timeout_o(timeout_o)
   );

   task automatic clear_reqs();
      for (int n = 0; n < 2; n++) begin
         tb_sel[n]  = 1'b0;
         tb_wr[n]   = 1'b0;
         tb_mask[n] = '0;
         tb_addr[n] = '0;
         tb_data[n] = '0;
      end
   endtask

   task automatic set_req(input int n, input logic wr, input logic [3:0] mask,
                          input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
      tb_sel[n]  = 1'b1;
      tb_wr[n]   = wr;
      tb_mask[n] = mask;
      tb_addr[n] = addr;
      tb_data[n] = data;
   endtask

   task automatic set_rand_req(input int n);
      set_req(n, 1'($urandom), 4'($urandom), ADDR_W'($urandom), DATA_W'($urandom));
   endtask

   // Round-robin rule: a lone requester wins, a tie goes to whoever was not served last.
   function automatic int predict_winner();
      if (tb_sel[0] && tb_sel[1]) return 1 - model_last;
      else if (tb_sel[1])         return 1;
      else                        return 0;
   endfunction

   task automatic wait_ssel(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (s_sel_o === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // Runs one transaction: slave acks on the lat-th edge after the grant edge.
   task automatic serve_txn(input int lat, input logic [DATA_W-1:0] rdata, output int w);
      bit ok;
      w = predict_winner();
      wait_ssel(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL grant_wait: s_sel_o never rose, expected owner M%0d", w);
         return;
      end
      checks++;
      if (grant_o !== 2'(1 << w) || s_wr_o !== tb_wr[w] || s_mask_o !== tb_mask[w] ||
          s_addr_o !== tb_addr[w] || s_data_o !== tb_data[w]) begin
         errors++;
         $display("FAIL grant_fields: got grant=%b wr=%b mask=%h addr=%h data=%h, expected grant=%b wr=%b mask=%h addr=%h data=%h",
                  grant_o, s_wr_o, s_mask_o, s_addr_o, s_data_o,
                  2'(1 << w), tb_wr[w], tb_mask[w], tb_addr[w], tb_data[w]);
      end
      for (int i = 1; i < lat; i++) begin
         @(negedge clk);
         checks++;
         if (s_sel_o !== 1'b1 || ack_v !== 2'b00 || s_addr_o !== tb_addr[w] ||
             s_data_o !== tb_data[w] || grant_o !== 2'(1 << w)) begin
            errors++;
            $display("FAIL busy_hold: got sel=%b ack=%b addr=%h data=%h grant=%b, expected sel=1 ack=00 addr=%h data=%h grant=%b",
                     s_sel_o, ack_v, s_addr_o, s_data_o, grant_o, tb_addr[w], tb_data[w], 2'(1 << w));
         end
      end
      s_ack_i  = 1'b1;
      s_data_i = rdata;
      @(negedge clk);
      s_ack_i  = 1'b0;
      s_data_i = DATA_W'($urandom);
      checks++;
      if (ack_v !== 2'(1 << w) || mdata[w] !== rdata || s_sel_o !== 1'b0) begin
         errors++;
         $display("FAIL ack_pulse: got ack=%b data=%h s_sel=%b, expected ack=%b data=%h s_sel=0",
                  ack_v, mdata[w], s_sel_o, 2'(1 << w), rdata);
      end
      model_last = w;
      tb_sel[w]  = 1'b0;
   endtask

   task automatic check_release();
      @(negedge clk);
      checks++;
      if (grant_o !== 2'b00 || ack_v !== 2'b00) begin
         errors++;
         $display("FAIL release: got grant=%b ack=%b, expected grant=00 ack=00", grant_o, ack_v);
      end
   endtask

   function automatic logic all_outputs_zero();
      return {s_sel_o, s_wr_o, s_mask_o, s_addr_o, s_data_o, grant_o, timeout_o,
              m0_ack_o, m1_ack_o, m0_data_o, m1_data_o} === '0;
   endfunction

   task automatic test_reset();
      int  w;
      bit  ok;
      reset_n_i = 1'b0;
      clear_reqs();
      s_ack_i  = 1'b0;
      s_data_i = '0;
      repeat (2) @(negedge clk);
      checks++;
      if (!all_outputs_zero()) begin
         errors++;
         $display("FAIL reset_idle: outputs not all zero (s_sel=%b grant=%b timeout=%b)", s_sel_o, grant_o, timeout_o);
      end
      reset_n_i  = 1'b1;
      model_last = 1;
      set_req(0, 1'b1, 4'hA, 24'h001234, 16'h5555);
      wait_ssel(ok);
      @(negedge clk);
      #2 reset_n_i = 1'b0;
      #1;
      checks++;
      if (!ok || !all_outputs_zero()) begin
         errors++;
         $display("FAIL reset_mid_busy: busy_reached=%0d s_sel=%b grant=%b s_addr=%h, expected all outputs 0",
                  ok, s_sel_o, grant_o, s_addr_o);
      end
      clear_reqs();
      @(negedge clk);
      reset_n_i  = 1'b1;
      model_last = 1;
      set_rand_req(0);
      set_rand_req(1);
      serve_txn(2, DATA_W'($urandom), w);
      check_release();
      serve_txn(1, DATA_W'($urandom), w);
      check_release();
   endtask

   task automatic test_write_m0();
      int w;
      set_req(0, 1'b1, 4'hF, 24'h000100, 16'hF00F);
      serve_txn(5, 16'h1111, w);
      check_release();
   endtask

   task automatic test_read_m1();
      int w;
      set_req(1, 1'b0, 4'h0, 24'h012C00, 16'h0000);
      serve_txn(3, 16'h0ABC, w);
      check_release();
   endtask

   task automatic test_alternate();
      int w;
      set_rand_req(0);
      set_rand_req(1);
      for (int i = 0; i < 6; i++) begin
         serve_txn(int'($urandom_range(1, 6)), DATA_W'($urandom), w);
         if (i < 5) set_rand_req(w);
         check_release();
      end
      clear_reqs();
   endtask

   task automatic test_timeout();
      int w;
      bit ok;
      set_req(0, 1'b0, 4'h3, 24'h00BEEF, 16'h0000);
      wait_ssel(ok);
      checks++;
      if (!ok || grant_o !== 2'b01) begin
         errors++;
         $display("FAIL timeout_grant: busy_reached=%0d grant=%b, expected grant=01", ok, grant_o);
      end
      for (int i = 0; i < TO - 1; i++) begin
         @(negedge clk);
         checks++;
         if (ack_v !== 2'b00 || s_sel_o !== 1'b1 || timeout_o !== 1'b0) begin
            errors++;
            $display("FAIL timeout_wait: cycle %0d ack=%b s_sel=%b timeout=%b, expected ack=00 s_sel=1 timeout=0",
                     i, ack_v, s_sel_o, timeout_o);
         end
      end
      @(negedge clk);
      checks++;
      if (ack_v !== 2'b01 || m0_data_o !== '0 || timeout_o !== 1'b1 || s_sel_o !== 1'b0) begin
         errors++;
         $display("FAIL timeout_fire: ack=%b data=%h timeout=%b s_sel=%b, expected ack=01 data=0000 timeout=1 s_sel=0",
                  ack_v, m0_data_o, timeout_o, s_sel_o);
      end
      tb_sel[0]  = 1'b0;
      model_last = 0;
      s_ack_i    = 1'b1;
      s_data_i   = 16'hDEAD;
      repeat (2) begin
         @(negedge clk);
         checks++;
         if (ack_v !== 2'b00 || grant_o !== 2'b00 || s_sel_o !== 1'b0 || m0_data_o !== '0) begin
            errors++;
            $display("FAIL late_ack: ack=%b grant=%b s_sel=%b data=%h, expected ack=00 grant=00 s_sel=0 data=0000",
                     ack_v, grant_o, s_sel_o, m0_data_o);
         end
      end
      s_ack_i = 1'b0;
      set_rand_req(0);
      serve_txn(2, 16'h7E57, w);
      checks++;
      if (timeout_o !== 1'b1) begin
         errors++;
         $display("FAIL timeout_sticky: timeout=%b, expected 1", timeout_o);
      end
      check_release();
   endtask

   task automatic test_back_to_back();
      int w;
      set_rand_req(0);
      serve_txn(2, DATA_W'($urandom), w);
      set_rand_req(0);
      set_rand_req(1);
      check_release();
      serve_txn(3, DATA_W'($urandom), w);
      check_release();
      serve_txn(1, DATA_W'($urandom), w);
      check_release();
   endtask

   task automatic test_random();
      int w;
      for (int i = 0; i < 25; i++) begin
         if (!tb_sel[0] && !tb_sel[1]) set_rand_req(int'($urandom_range(0, 1)));
         serve_txn(int'($urandom_range(1, 6)), DATA_W'($urandom), w);
         for (int n = 0; n < 2; n++)
            if (!tb_sel[n] && ($urandom_range(0, 1) == 1)) set_rand_req(n);
         check_release();
      end
      clear_reqs();
   endtask

   initial begin
      test_reset();
      test_write_m0();
      test_read_m1();
      test_alternate();
      test_timeout();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached after %0d checks", checks);
      $fatal(1, "watchdog expired");
   end

endmodule
